// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 transmit-side emulator: RGB444 widths,
// default VGA timing, pattern encodings and the color-bar table.
package ov7670_pkg;

   localparam int R_W   = 4;
   localparam int G_W   = 4;
   localparam int B_W   = 4;
   localparam int RGB_W = R_W + G_W + B_W;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_TOTAL  = 784;
   localparam int DEF_V_SYNC   = 3;
   localparam int DEF_V_BP     = 17;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_TOTAL  = 510;

   typedef enum logic [1:0] {
      PAT_BARS  = 2'd0,
      PAT_RAMP  = 2'd1,
      PAT_SOLID = 2'd2,
      PAT_CHECK = 2'd3
   } pattern_t;

   typedef enum logic {
      ST_IDLE,
      ST_FRAME
   } state_t;

   // Bar 0 (white) sits in the least significant slot.
   localparam logic [8*RGB_W-1:0] BAR_TABLE = {
      12'h000, 12'h00F, 12'hF00, 12'hF0F,
      12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
   };

   function automatic logic [RGB_W-1:0] bar_color(input logic [2:0] idx);
      return BAR_TABLE[int'(idx)*RGB_W +: RGB_W];
   endfunction

endpackage

// File: rtl/ov7670_tx_pattern_gen.sv
// Combinational test-pattern map (pattern, x, y, solid) -> RGB444.
// The checkerboard is only built when OV7670_TX_CHECKER_EN is defined.
module ov7670_tx_pattern_gen
   import ov7670_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int XW       = 10
)
(
   input  pattern_t         pattern,
   input  logic [XW-1:0]    x,
`ifdef OV7670_TX_CHECKER_EN
   input  logic             y_tile,
`endif
   input  logic [RGB_W-1:0] solid,
   output logic [RGB_W-1:0] rgb
);

   localparam int BAR_W = H_ACTIVE / 8;

   logic [2:0]       bar_idx;
   logic [RGB_W-1:0] bars_rgb;

   // Threshold compare instead of a divider keeps the bar index at 3 bits.
   always_comb begin
      bar_idx = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (int'(x) >= k * BAR_W) begin
            bar_idx = 3'(k);
         end
      end
   end

   assign bars_rgb = bar_color(bar_idx);

   always_comb begin
      rgb = bars_rgb;
      case (pattern)
         PAT_RAMP:  rgb = {x[5:2], x[5:2], x[5:2]};
         PAT_SOLID: rgb = solid;
`ifdef OV7670_TX_CHECKER_EN
         PAT_CHECK: rgb = (x[3] ^ y_tile) ? 12'h000 : 12'hFFF;
`endif
         default:   rgb = bars_rgb;
      endcase
   end

endmodule

// File: rtl/ov7670_tx_emulator.sv
// OV7670 camera-side emulator: PCLK/VSYNC/HREF/D[7:0] in RGB444 with VGA timing.
// Define OV7670_TX_CHECKER_EN to make pattern 3 an 8x8 checkerboard.
module ov7670_tx_emulator
   import ov7670_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_TOTAL  = DEF_H_TOTAL,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_TOTAL  = DEF_V_TOTAL
)
(
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_enable,
   input  logic [1:0]       i_pattern,
   input  logic [RGB_W-1:0] i_solid_rgb,
   output logic             o_PCLK,
   output logic             o_VS,
   output logic             o_HS,
   output logic [7:0]       o_DATA,
   output logic             o_frame_done,
   output logic             o_busy
);

   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_TOTAL + 1);
   localparam int XW      = (HW < 6) ? 6 : HW;
   localparam int V_START = V_SYNC + V_BP;
   localparam int V_END   = V_START + V_ACTIVE;

   localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT       = HW'(H_ACTIVE);
   localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_SYNC_END  = VW'(V_SYNC);
   localparam logic [VW-1:0] V_ACT_START = VW'(V_START);
   localparam logic [VW-1:0] V_ACT_END   = VW'(V_END);

   if (V_END > V_TOTAL || H_ACTIVE >= H_TOTAL || (H_ACTIVE % 8) != 0) begin : g_bad_params
      $error("ov7670_tx_emulator: inconsistent timing parameters");
   end

   state_t           state;
   logic             pclk_ph;
   logic             byte_sel;
   logic [HW-1:0]    h_cnt;
   logic [VW-1:0]    v_cnt;
   pattern_t         pat_q;
   logic [RGB_W-1:0] solid_q;

   logic             at_last;
   logic             load;
   logic             run;
   logic             n_ph;
   logic             n_bs;
   logic [HW-1:0]    n_h;
   logic [VW-1:0]    n_v;
   pattern_t         n_pat;
   logic [RGB_W-1:0] n_solid;
   logic             n_vs;
   logic             n_hs;
   logic             n_last;
   logic [RGB_W-1:0] rgb;
   logic [7:0]       n_byte;

   assign at_last = (state == ST_FRAME) && pclk_ph && byte_sel &&
                    (h_cnt == H_LAST) && (v_cnt == V_LAST);
   assign load    = i_enable && ((state == ST_IDLE) || at_last);
   assign run     = load || ((state == ST_FRAME) && !at_last);

   // Outputs are derived from the position the counters move to on this edge,
   // so the registered outputs line up with the counters they describe.
   always_comb begin
      n_ph    = ~pclk_ph;
      n_bs    = byte_sel;
      n_h     = h_cnt;
      n_v     = v_cnt;
      n_pat   = pat_q;
      n_solid = solid_q;
      if (load) begin
         n_ph    = 1'b0;
         n_bs    = 1'b0;
         n_h     = '0;
         n_v     = '0;
         n_pat   = pattern_t'(i_pattern);
         n_solid = i_solid_rgb;
      end else if (pclk_ph) begin
         n_bs = ~byte_sel;
         if (byte_sel) begin
            if (h_cnt == H_LAST) begin
               n_h = '0;
               n_v = v_cnt + 1'b1;
            end else begin
               n_h = h_cnt + 1'b1;
            end
         end
      end
   end

   assign n_vs   = (n_v < V_SYNC_END);
   assign n_hs   = (n_v >= V_ACT_START) && (n_v < V_ACT_END) && (n_h < H_ACT);
   assign n_last = n_ph && n_bs && (n_h == H_LAST) && (n_v == V_LAST);
   assign n_byte = n_bs ? rgb[G_W+B_W-1:0] : {4'h0, rgb[RGB_W-1 -: R_W]};

`ifdef OV7670_TX_CHECKER_EN
   logic [3:0] y_cnt;
   logic [3:0] n_y;

   // Only the row-tile parity matters, so the active-line index wraps mod 16.
   always_comb begin
      n_y = y_cnt;
      if (load) begin
         n_y = 4'd0;
      end else if (pclk_ph && byte_sel && (h_cnt == H_LAST) &&
                   (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END)) begin
         n_y = y_cnt + 4'd1;
      end
   end
`endif

   ov7670_tx_pattern_gen #(
      .H_ACTIVE (H_ACTIVE),
      .XW       (XW)
   ) u_pattern_gen (
      .pattern  (n_pat),
      .x        (XW'(n_h)),
`ifdef OV7670_TX_CHECKER_EN
      .y_tile   (n_y[3]),
`endif
      .solid    (n_solid),
      .rgb      (rgb)
   );

   // Frame FSM; VS/HS/DATA only move on the edge that drives PCLK low.
   always_ff @(posedge i_clk) begin
      if (i_reset || !run) begin
         state        <= ST_IDLE;
         pclk_ph      <= 1'b0;
         byte_sel     <= 1'b0;
         h_cnt        <= '0;
         v_cnt        <= '0;
         o_PCLK       <= 1'b0;
         o_VS         <= 1'b0;
         o_HS         <= 1'b0;
         o_DATA       <= 8'h00;
         o_frame_done <= 1'b0;
         o_busy       <= 1'b0;
         if (i_reset) begin
            pat_q   <= PAT_BARS;
            solid_q <= '0;
         end
`ifdef OV7670_TX_CHECKER_EN
         y_cnt <= 4'd0;
`endif
      end else begin
         state        <= ST_FRAME;
         pclk_ph      <= n_ph;
         byte_sel     <= n_bs;
         h_cnt        <= n_h;
         v_cnt        <= n_v;
         pat_q        <= n_pat;
         solid_q      <= n_solid;
         o_PCLK       <= n_ph;
         o_busy       <= 1'b1;
         o_frame_done <= n_last;
         if (!n_ph) begin
            o_VS   <= n_vs;
            o_HS   <= n_hs;
            o_DATA <= n_hs ? n_byte : 8'h00;
         end
`ifdef OV7670_TX_CHECKER_EN
         y_cnt <= n_y;
`endif
      end
   end

endmodule

// File: doc/ov7670_tx_emulator.md
# ov7670_tx_emulator

Synthesizable OV7670 sensor emulator that generates the camera-side parallel interface (PCLK, VSYNC, HREF, D[7:0]) in RGB444 two-bytes-per-pixel format with OV7670 VGA frame timing. It drives the capture path (receiver → frame-buffer BRAM) in simulation and on-board loopback without a physical camera. It produces deterministic test patterns, so every downstream pixel and address is predictable.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_TOTAL, 784, pixel periods per line, including blanking
- V_SYNC, 3, lines with VSYNC high
- V_BP, 17, blank lines between the end of VSYNC and the first active line
- V_ACTIVE, 480, active lines
- V_TOTAL, 510, lines per frame
- i_clk  in  1  system clock; one PCLK period = 2 i_clk cycles
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  level; run frames while high
- i_pattern  in  2  pattern select; sampled at frame start
- i_solid_rgb  in  12  {R,G,B} 4 bits each, used by the solid pattern; sampled at frame start
- o_PCLK  out  1  emulated pixel clock
- o_VS  out  1  VSYNC, active high
- o_HS  out  1  HREF, high during active bytes
- o_DATA  out  8  pixel byte
- o_frame_done  out  1  one-cycle pulse at the end of each frame
- o_busy  out  1  high while a frame is in progress

## Operation
- Counters:
  - pclk_ph (1b)
  - byte_sel (1b)
  - h_cnt (0..H_TOTAL-1)
  - v_cnt (0..V_TOTAL-1)
- h_cnt advances once per pixel, which is 2 PCLK periods = 4 i_clk cycles.
- States:
  - IDLE: all outputs 0. i_enable=1 → FRAME, with counters 0 and i_pattern / i_solid_rgb latched.
  - FRAME: counters run. At the last byte of the last line (v_cnt=V_TOTAL-1, h_cnt=H_TOTAL-1, byte_sel=1, pclk_ph=1):
    - pulse o_frame_done;
    - if i_enable=1, restart at count 0 and re-latch i_pattern / i_solid_rgb;
    - otherwise go to IDLE.
- Deasserting i_enable mid-frame never truncates the frame; the frame completes first.
- o_VS = (v_cnt < V_SYNC).
- o_HS is high when both hold:
  - V_SYNC+V_BP ≤ v_cnt < V_SYNC+V_BP+V_ACTIVE
  - h_cnt < H_ACTIVE
- o_DATA, when o_HS=1:
  - byte 0 = {4'h0, R}
  - byte 1 = {G, B}
- o_DATA = 8'h00 whenever o_HS=0.
- Patterns (x = h_cnt, y = active line index):
  - 0 — color bars: 8 bars, each H_ACTIVE/8 wide. Order: white FFF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000.
  - 1 — ramp: R=G=B=x[5:2].
  - 2 — solid: latched i_solid_rgb.
  - 3 — see Configuration.
- o_busy = (state == FRAME).

## Timing
- Reset values: o_PCLK=0, o_VS=0, o_HS=0, o_DATA=0, o_frame_done=0, o_busy=0, state IDLE. Reset mid-frame takes effect on the next edge, with no frame_done pulse.
- o_PCLK: low in pclk_ph=0, high in pclk_ph=1.
- o_DATA, o_HS and o_VS change only on the i_clk edge that drives o_PCLK low. They are stable across the rising PCLK edge, giving one i_clk of setup and one of hold.
- All outputs are registered.
- Start latency: i_enable sampled high in IDLE → o_busy=1 and o_VS=1 at the next edge.
- Frame length: V_TOTAL·H_TOTAL·4 i_clk cycles. At defaults this is 1,599,360.
- Per active line: 2·H_ACTIVE rising PCLK edges with o_HS=1.
- o_frame_done is coincident with the last PCLK-high cycle of the frame.
- Parameter constraints: V_SYNC+V_BP+V_ACTIVE ≤ V_TOTAL, H_ACTIVE < H_TOTAL, H_ACTIVE divisible by 8. These are checked by an elaboration-time assertion.

## Configuration
- OV7670_TX_CHECKER_EN defined:
  - i_pattern=3 selects an 8×8 checkerboard: FFF when x[3]^y[3] = 0, 000 otherwise.
  - y counter logic is compiled in.
- OV7670_TX_CHECKER_EN undefined:
  - i_pattern=3 behaves as pattern 0 (color bars).
  - No y counter or checker logic is present.

## Structure
- Shared package ov7670_pkg holds:
  - RGB444 field widths;
  - default VGA timing constants (640/784/3/17/480/510);
  - pattern encodings PAT_BARS/PAT_RAMP/PAT_SOLID/PAT_CHECK;
  - the 8-entry color-bar constant table.
- One sub-module: ov7670_tx_pattern_gen, a combinational map (pattern, x, y, latched solid) → 12-bit RGB. The top module holds the FSM, counters and output registers.

## Test plan
- Reset: hold i_reset 3 cycles with i_enable=1 → all outputs 0, o_busy=0. Release → o_VS=1 one cycle later.
- Line timing, with H_ACTIVE=16, H_TOTAL=20, V_SYNC=1, V_BP=1, V_ACTIVE=4, V_TOTAL=8:
  - each active line → exactly 32 rising PCLK edges with o_HS=1;
  - each frame → 640 i_clk cycles between o_frame_done pulses.
- Color bars, default params: first two bytes of the first active line are 0x0F, 0xFF. Bytes at x=80 are 0x0F, 0xF0 (yellow). Bytes at x=560 are 0x00, 0x00.
- Solid: i_solid_rgb=12'hA5C → every active byte pair is 0x0A, 0x5C. Changing i_solid_rgb mid-frame → no effect until the next frame.
- Stop/restart: drop i_enable mid-frame → frame completes, one o_frame_done, then IDLE. With i_enable held high, frames run back-to-back with VS rising directly after o_frame_done.
- Checker, with the macro defined: i_pattern=3 → pixel (8,0) is 000 and pixel (8,8) is FFF. Without the macro → output identical to pattern 0.
